// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Operands are reduced to magnitudes on capture; the sign is applied when the result is latched.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 iterative steps in progress, busy high
// DONE  | one-cycle result pulse; a new start may be accepted here
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             in_neg, div_zero, div_ovf;
    logic [WIDTH-1:0] bypass_res;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed && bus_a[WIDTH-1];
        b_neg    = b_signed && bus_b[WIDTH-1];
        a_mag    = a_neg ? (ZERO - bus_a) : bus_a;
        b_mag    = b_neg ? (ZERO - bus_b) : bus_b;
        // Remainders follow the dividend's sign; everything else uses the product/quotient sign.
        in_neg   = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = op[2] && (bus_b == ZERO);
        div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (bus_a == MIN_NEG) && (bus_b == ALL_ONE);
        if (div_zero) begin
            bypass_res = op[1] ? bus_a : ALL_ONE;
        end else begin
            bypass_res = op[1] ? ZERO : MIN_NEG;
        end
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mcand_q};
        // When the subtraction succeeds the true difference fits in WIDTH bits.
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod_raw = {step_hi, step_lo};
        prod_fix = neg_q ? ({(2*WIDTH){1'b0}} - prod_raw) : prod_raw;
        quo_fix  = neg_q ? (ZERO - step_lo) : step_lo;
        rem_fix  = neg_q ? (ZERO - step_hi) : step_hi;
        case (op_q)
            OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              final_res = quo_fix;
            OP_REM, OP_REMU:              final_res = rem_fix;
            default:                      final_res = ZERO;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_d    = op;
                    neg_d   = in_neg;
                    hi_d    = ZERO;
                    lo_d    = a_mag;
                    mcand_d = b_mag;
                    cnt_d   = '0;
                    if (div_zero || div_ovf) begin
                        state_d  = DONE;
                        result_d = bypass_res;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d  = DONE;
                        result_d = final_res;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
            hi_q     <= ZERO;
            lo_q     <= ZERO;
            mcand_q  <= ZERO;
            result_q <= ZERO;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, bypass cases, abort, reset and back-to-back.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] bus_a = 32'd0;
    logic [31:0] bus_b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .bus_a (bus_a),
        .bus_b (bus_b),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives start for one cycle, then scrambles the inputs to prove they were captured.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; bus_a = a; bus_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; bus_a = ~a; bus_b = b ^ 32'h5A5A_0001;
    endtask

    // Samples cycles 1..max_cyc (1 ns after each edge); optionally injects abort/start at inj_cyc.
    task automatic wait_done(input int max_cyc, input int inj_cyc, input bit inj_abort,
                             input bit inj_start, output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
            if (c == inj_cyc) begin
                abort = inj_abort;
                start = inj_start;
                if (inj_start) begin
                    op = 3'd5; bus_a = 32'd100; bus_b = 32'd7;
                end
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat, bc;
        issue(o, a, b);
        wait_done(40, 0, 1'b0, 1'b0, lat, bc);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bc, exp_lat - 1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, result, exp);
        @(posedge clk); #1;
        check({tag, "_done_single"}, {31'd0, done}, 32'd0);
        check({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int lat, bc;
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        #20 rst = 1'b0;

        // First start issued right after reset release, accepted on the next edge.
        run_op("mul",     3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33);
        run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("divu",    3'd5, 32'd100,      32'd7,        32'd14,        33);
        run_op("remu",    3'd7, 32'd100,      32'd7,        32'd2,         33);
        run_op("divu_z",  3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("remu_z",  3'd7, 32'd9,        32'd0,        32'd9,         1);

        // Abort in cycle 10 of MUL 3*4; restart in cycle 12 with a stray start mid-CALC.
        issue(3'd0, 32'd3, 32'd4);
        wait_done(11, 10, 1'b1, 1'b0, lat, bc);
        check("abort_no_done", lat, 0);
        check("abort_busy_cycles", bc, 10);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_idle_done", {31'd0, done}, 32'd0);
        check("abort_result_kept", result, 32'd9);
        issue(3'd0, 32'd3, 32'd4);
        wait_done(40, 5, 1'b0, 1'b1, lat, bc);
        check("restart_lat", lat, 33);
        check("restart_result", result, 32'd12);
        @(posedge clk); #1;
        check("restart_no_queue_busy", {31'd0, busy}, 32'd0);
        check("restart_no_queue_done", {31'd0, done}, 32'd0);

        // Reset in cycle 15 of a DIV, checked between clock edges.
        issue(3'd4, 32'd100, 32'd7);
        wait_done(14, 0, 1'b0, 1'b0, lat, bc);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_done", {31'd0, done}, 32'd0);
        check("rst_async_result", result, 32'd0);
        #2 rst = 1'b0;
        wait_done(40, 0, 1'b0, 1'b0, lat, bc);
        check("rst_no_done", lat, 0);
        check("rst_no_busy", bc, 0);

        // Back-to-back: second start issued in the DONE cycle of the first.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(40, 0, 1'b0, 1'b0, lat, bc);
        check("b2b_first_lat", lat, 33);
        check("b2b_first_result", result, 32'hFFFF_FFFE);
        issue(3'd5, 32'd100, 32'd7);
        check("b2b_gap_done", {31'd0, done}, 32'd0);
        check("b2b_gap_busy", {31'd0, busy}, 32'd1);
        wait_done(40, 0, 1'b0, 1'b0, lat, bc);
        check("b2b_second_lat", lat, 33);
        check("b2b_second_busy", bc, 32);
        check("b2b_second_result", result, 32'd14);
        @(posedge clk); #1;
        check("b2b_done_single", {31'd0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
